// File: rtl/iterative_shifter_if.sv
// Request/response bundle between the ALU stall logic and the iterative shifter.
// Handshake: start is looked at only while the shifter is idle or done (busy=0);
// busy is high while shifting; result_rdy pulses for one cycle with result valid.
interface iterative_shifter_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               start;
   logic [1:0]         op;
   logic [WIDTH-1:0]   data_in;
   logic [SHAMT_W-1:0] shamt;
   logic               busy;
   logic               result_rdy;
   logic [WIDTH-1:0]   result;

   modport master (
      output start, op, data_in, shamt,
      input  busy, result_rdy, result
   );

   modport slave (
      input  start, op, data_in, shamt,
      output busy, result_rdy, result
   );
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: SLL/SRA/SRL (and ROR when SHIFTER_ROTATE_EN is defined),
// consuming up to STEP bits of the shift amount per clock.
module iterative_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 4
) (
   input  logic                clock,
   input  logic                reset,
   iterative_shifter_if.slave  bus,
   output logic [1:0]          state_dbg_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   localparam logic [SHAMT_W-1:0] STEP_L = SHAMT_W'(STEP);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [1:0]         op_q, op_d;
   logic               sign_q, sign_d;

   logic [SHAMT_W-1:0] step_k;
   logic [SHAMT_W-1:0] rem_after;
   logic [WIDTH-1:0]   srl_val;
   logic [WIDTH-1:0]   fill_mask;
   logic [WIDTH-1:0]   shifted;
`ifdef SHIFTER_ROTATE_EN
   logic [SHAMT_W-1:0] rot_amt;
`endif

   // One shift step of size k = min(remaining, STEP) on the working register.
   always_comb begin
      step_k    = (rem_q < STEP_L) ? rem_q : STEP_L;
      rem_after = rem_q - step_k;
      srl_val   = work_q >> step_k;
      fill_mask = ~({WIDTH{1'b1}} >> step_k);
`ifdef SHIFTER_ROTATE_EN
      rot_amt   = SHAMT_W'(WIDTH - int'(step_k));
`endif
      case (op_q)
         2'b00:   shifted = work_q << step_k;
         2'b01:   shifted = srl_val | (fill_mask & {WIDTH{sign_q}});
         2'b10:   shifted = srl_val;
`ifdef SHIFTER_ROTATE_EN
         2'b11:   shifted = srl_val | (work_q << rot_amt);
`else
         2'b11:   shifted = srl_val;
`endif
         default: shifted = srl_val;
      endcase
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      op_d    = op_q;
      sign_d  = sign_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               work_d  = bus.data_in;
               op_d    = bus.op;
               rem_d   = bus.shamt;
               sign_d  = bus.data_in[WIDTH-1];
               state_d = (bus.shamt != '0) ? S_SHIFT : S_DONE;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            work_d = shifted;
            rem_d  = rem_after;
            if (rem_after == '0) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         rem_q   <= '0;
         op_q    <= 2'b00;
         sign_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         sign_q  <= sign_d;
      end
   end

   assign bus.busy       = (state_q == S_SHIFT);
   assign bus.result_rdy = (state_q == S_DONE);
   assign bus.result     = work_q;
   assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter (WIDTH=32, STEP=4); expectations hand-computed.
module tb_iterative_shifter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] state_dbg;
   int         pass_cnt  = 0;
   int         total_cnt = 0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   iterative_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

   iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus.slave),
      .state_dbg_o (state_dbg)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Accepts one operation, then walks the expected busy window and the ready cycle.
   // A start pulse is injected during SHIFT cycle 'poke' (0 = none); it must be ignored.
   task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                         input logic [31:0] exp, input int poke, input string tag);
      int lat;
      lat = (int'(s) + 3) / 4;
      bus.start   = 1'b1;
      bus.op      = o;
      bus.data_in = d;
      bus.shamt   = s;
      step();
      bus.start = 1'b0;
      for (int c = 1; c <= lat; c++) begin
         check({tag, "_busy"}, 32'(bus.busy), 32'd1);
         check({tag, "_early_rdy"}, 32'(bus.result_rdy), 32'd0);
         if (c == poke) begin
            bus.start   = 1'b1;
            bus.op      = 2'b00;
            bus.data_in = 32'h0;
            bus.shamt   = 5'd0;
         end else begin
            bus.start = 1'b0;
         end
         step();
      end
      bus.start = 1'b0;
      check({tag, "_rdy"}, 32'(bus.result_rdy), 32'd1);
      check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
      check({tag, "_result"}, bus.result, exp);
      check({tag, "_state"}, 32'(state_dbg), 32'(ST_DONE));
   endtask

   initial begin
      int rdy_seen;
      bus.start   = 1'b0;
      bus.op      = 2'b00;
      bus.data_in = 32'h0;
      bus.shamt   = 5'd0;

      reset = 1'b1;
      step();
      step();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_rdy", 32'(bus.result_rdy), 32'd0);
      check("rst_result", bus.result, 32'h0);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      reset = 1'b0;
      step();

      run_op(2'b01, 32'h8000_0000, 5'd1, 32'hC000_0000, 0, "sra1");
      step();
      check("sra1_idle", 32'(state_dbg), 32'(ST_IDLE));
      check("sra1_rdy_pulse", 32'(bus.result_rdy), 32'd0);

      run_op(2'b01, 32'h8000_0010, 5'd31, 32'hFFFF_FFFF, 4, "sra31");
      step();

      run_op(2'b00, 32'h0000_0001, 5'd5, 32'h0000_0020, 0, "sll5");
      run_op(2'b10, 32'hF000_0000, 5'd4, 32'h0F00_0000, 0, "srl4_b2b");
      step();
      check("hold_result", bus.result, 32'h0F00_0000);
      check("hold_idle", 32'(state_dbg), 32'(ST_IDLE));

      run_op(2'b01, 32'h1234_5678, 5'd0, 32'h1234_5678, 0, "zero");
      step();

      run_op(2'b10, 32'h8000_0000, 5'd31, 32'h0000_0001, 0, "srl31");
      run_op(2'b00, 32'h0000_0003, 5'd6, 32'h0000_00C0, 0, "sll6_b2b");
      step();

      // Abort: reset (with start) arrives during cycle 3 of a long SRA.
      bus.start   = 1'b1;
      bus.op      = 2'b01;
      bus.data_in = 32'h8000_0000;
      bus.shamt   = 5'd20;
      step();
      bus.start = 1'b0;
      step();
      step();
      reset       = 1'b1;
      bus.start   = 1'b1;
      bus.op      = 2'b00;
      bus.data_in = 32'h0000_00FF;
      bus.shamt   = 5'd0;
      step();
      reset     = 1'b0;
      bus.start = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_rdy", 32'(bus.result_rdy), 32'd0);
      check("abort_result", bus.result, 32'h0);
      check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
      rdy_seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.result_rdy) rdy_seen++;
      end
      check("abort_no_rdy", 32'(rdy_seen), 32'd0);

      run_op(2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002, 0, "sll1_after_abort");
      step();

`ifdef SHIFTER_ROTATE_EN
      run_op(2'b11, 32'h0000_0001, 5'd1, 32'h8000_0000, 0, "ror1");
      step();
      run_op(2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456, 0, "ror8");
      step();
`else
      run_op(2'b11, 32'h0000_0001, 5'd1, 32'h0000_0000, 0, "op3_srl1");
      step();
      run_op(2'b11, 32'h1234_5678, 5'd8, 32'h0012_3456, 0, "op3_srl8");
      step();
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
